// File: rtl/acl2_stream_group_assembler.sv
// acl2_stream_group_assembler
// Collects a framed byte stream from the ACL2 SPI driver into one wide word.
// Group length and byte order are latched at group start. A short group or extra
// bytes are flagged on publish, and every publish advances a wrapping sequence count.
module acl2_stream_group_assembler #(
    parameter int parm_bytes_max = 8,
    parameter int parm_cnt_bits  = 4,
    parameter int parm_seq_bits  = 8
) (
    input  logic                          i_clk_20mhz,
    input  logic                          i_rst_20mhz,
    input  logic                          i_group_valid,
    input  logic                          i_byte_valid,
    input  logic [7:0]                    i_byte_data,
    input  logic [parm_cnt_bits-1:0]      i_group_len,
    input  logic                          i_order,
    output logic [8*parm_bytes_max-1:0]   o_data,
    output logic                          o_data_valid,
    output logic [parm_cnt_bits-1:0]      o_byte_count,
    output logic                          o_err_short,
    output logic                          o_err_overrun,
    output logic [parm_seq_bits-1:0]      o_group_seq,
    output logic                          o_busy
);

    localparam int W = 8 * parm_bytes_max;
    localparam logic [parm_cnt_bits-1:0] C_MAX = parm_cnt_bits'(parm_bytes_max);
    localparam logic [parm_cnt_bits-1:0] C_ONE = parm_cnt_bits'(1);

    typedef enum logic [1:0] {
        ST_WAIT_GROUP,
        ST_CAPTURE,
        ST_WAIT_END
    } state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;

    logic [W-1:0]               r_sr;
    logic [W-1:0]               w_sr_nxt;
    logic [W-1:0]               w_sr_ins;
    logic [parm_cnt_bits-1:0]   r_cnt;
    logic [parm_cnt_bits-1:0]   w_cnt_nxt;
    logic [parm_cnt_bits-1:0]   r_len;
    logic [parm_cnt_bits-1:0]   w_len_nxt;
    logic                       r_order;
    logic                       w_order_nxt;
    logic                       r_ovr;
    logic                       w_ovr_nxt;
    logic                       w_publish;
    logic                       w_short;

    logic [W-1:0]               r_data;
    logic                       r_data_valid;
    logic [parm_cnt_bits-1:0]   r_byte_count;
    logic                       r_err_short;
    logic                       r_err_overrun;
    logic [parm_seq_bits-1:0]   r_group_seq;

    // Current shift register with the incoming byte merged in the latched byte order.
    always_comb begin
        w_sr_ins = r_sr;
        if (r_order) begin
            for (int unsigned k = 0; k < parm_bytes_max; k++) begin
                if (r_cnt == parm_cnt_bits'(k)) begin
                    w_sr_ins[8*k +: 8] = i_byte_data;
                end
            end
        end else begin
            w_sr_ins = {r_sr[W-9:0], i_byte_data};
        end
    end

    // Next-state, capture datapath and publish decision.
    always_comb begin
        w_state_nxt = r_state;
        w_sr_nxt    = r_sr;
        w_cnt_nxt   = r_cnt;
        w_len_nxt   = r_len;
        w_order_nxt = r_order;
        w_ovr_nxt   = r_ovr;
        w_publish   = 1'b0;
        w_short     = 1'b0;
        case (r_state)
            ST_WAIT_GROUP: begin
                w_sr_nxt  = '0;
                w_cnt_nxt = '0;
                w_ovr_nxt = 1'b0;
                if (i_group_valid) begin
                    w_len_nxt   = ((i_group_len == '0) || (i_group_len > C_MAX)) ? C_MAX : i_group_len;
                    w_order_nxt = i_order;
                    w_state_nxt = ST_CAPTURE;
                    // A byte on the rising cycle is byte 0; the cleared register makes both orders agree.
                    if (i_byte_valid) begin
                        w_sr_nxt  = {{(W-8){1'b0}}, i_byte_data};
                        w_cnt_nxt = C_ONE;
                        if (w_len_nxt == C_ONE) begin
                            w_state_nxt = ST_WAIT_END;
                        end
                    end
                end
            end
            ST_CAPTURE: begin
                if (i_byte_valid) begin
                    w_sr_nxt  = w_sr_ins;
                    w_cnt_nxt = r_cnt + C_ONE;
                end
                if (!i_group_valid) begin
                    w_publish   = 1'b1;
                    w_short     = (w_cnt_nxt < r_len);
                    w_state_nxt = ST_WAIT_GROUP;
                end else if (w_cnt_nxt == r_len) begin
                    w_state_nxt = ST_WAIT_END;
                end
            end
            ST_WAIT_END: begin
                if (i_byte_valid) begin
                    w_ovr_nxt = 1'b1;
                end
                if (!i_group_valid) begin
                    w_publish   = 1'b1;
                    w_state_nxt = ST_WAIT_GROUP;
                end
            end
            default: begin
                w_state_nxt = ST_WAIT_GROUP;
            end
        endcase
    end

    // State and capture registers.
    always_ff @(posedge i_clk_20mhz) begin
        if (i_rst_20mhz) begin
            r_state <= ST_WAIT_GROUP;
            r_sr    <= '0;
            r_cnt   <= '0;
            r_len   <= '0;
            r_order <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_sr    <= w_sr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_len   <= w_len_nxt;
            r_order <= w_order_nxt;
            r_ovr   <= w_ovr_nxt;
        end
    end

    // Registered publish: outputs hold until the next group is published.
    always_ff @(posedge i_clk_20mhz) begin
        if (i_rst_20mhz) begin
            r_data        <= '0;
            r_data_valid  <= 1'b0;
            r_byte_count  <= '0;
            r_err_short   <= 1'b0;
            r_err_overrun <= 1'b0;
            r_group_seq   <= '0;
        end else begin
            r_data_valid <= w_publish;
            if (w_publish) begin
                r_data        <= w_sr_nxt;
                r_byte_count  <= w_cnt_nxt;
                r_err_short   <= w_short;
                r_err_overrun <= w_ovr_nxt;
                r_group_seq   <= r_group_seq + parm_seq_bits'(1);
            end
        end
    end

    assign o_data        = r_data;
    assign o_data_valid  = r_data_valid;
    assign o_byte_count  = r_byte_count;
    assign o_err_short   = r_err_short;
    assign o_err_overrun = r_err_overrun;
    assign o_group_seq   = r_group_seq;
    assign o_busy        = (r_state != ST_WAIT_GROUP);

endmodule

// File: tb/tb_acl2_stream_group_assembler.sv
// Testbench for acl2_stream_group_assembler: directed groups plus randomized groups
// checked against a queue-based reference model of the group rules.
module tb_acl2_stream_group_assembler;

    logic        clk = 1'b0;
    logic        rst;
    logic        group_valid;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic [3:0]  group_len;
    logic        order;
    logic [63:0] data;
    logic        data_valid;
    logic [3:0]  byte_count;
    logic        err_short;
    logic        err_overrun;
    logic [7:0]  group_seq;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_seq = 0;

    acl2_stream_group_assembler #(
        .parm_bytes_max(8),
        .parm_cnt_bits (4),
        .parm_seq_bits (8)
    ) dut (
        .i_clk_20mhz  (clk),
        .i_rst_20mhz  (rst),
        .i_group_valid(group_valid),
        .i_byte_valid (byte_valid),
        .i_byte_data  (byte_data),
        .i_group_len  (group_len),
        .i_order      (order),
        .o_data       (data),
        .o_data_valid (data_valid),
        .o_byte_count (byte_count),
        .o_err_short  (err_short),
        .o_err_overrun(err_overrun),
        .o_group_seq  (group_seq),
        .o_busy       (busy)
    );

    always #5 clk = ~clk;

    // Drives one group starting at the current negedge and checks its publish.
    task automatic run_group(input string tag, input int len_in, input bit ord, input int nb,
                             input bit b_rise, input bit b_fall, input int base, input bit gaps);
        logic [7:0]  q[$];
        bit          plan[$];
        logic [7:0]  b;
        logic [63:0] exp_d;
        int          mid;
        int          eff;
        int          kept;
        mid = nb - int'(b_rise) - int'(b_fall);
        for (int i = 0; i < mid; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) plan.push_back(1'b0);
            plan.push_back(1'b1);
        end
        group_valid = 1'b1;
        group_len   = 4'(len_in);
        order       = ord;
        b = (base >= 0) ? 8'(base + q.size()) : 8'($urandom);
        byte_valid = b_rise;
        byte_data  = b;
        if (b_rise) q.push_back(b);
        @(negedge clk);
        group_len = 4'($urandom);
        order     = 1'($urandom);
        foreach (plan[i]) begin
            n_cmp++;
            if (data_valid !== 1'b0) begin
                n_bad++; $display("FAIL %s early_publish: got %b expected 0", tag, data_valid);
            end
            n_cmp++;
            if (busy !== 1'b1) begin
                n_bad++; $display("FAIL %s busy_in_group: got %b expected 1", tag, busy);
            end
            b = (base >= 0) ? 8'(base + q.size()) : 8'($urandom);
            byte_valid = plan[i];
            byte_data  = b;
            if (plan[i]) q.push_back(b);
            @(negedge clk);
        end
        n_cmp++;
        if (data_valid !== 1'b0) begin
            n_bad++; $display("FAIL %s early_publish: got %b expected 0", tag, data_valid);
        end
        group_valid = 1'b0;
        b = (base >= 0) ? 8'(base + q.size()) : 8'($urandom);
        byte_valid = b_fall;
        byte_data  = b;
        if (b_fall) q.push_back(b);
        @(negedge clk);
        byte_valid = 1'b0;

        eff  = (len_in == 0 || len_in > 8) ? 8 : len_in;
        kept = (q.size() < eff) ? q.size() : eff;
        exp_d = '0;
        for (int k = 0; k < kept; k++) begin
            if (!ord) exp_d = (exp_d << 8) | 64'(q[k]);
            else      exp_d = exp_d | (64'(q[k]) << (8 * k));
        end
        exp_seq = (exp_seq + 1) % 256;

        n_cmp++;
        if (data_valid !== 1'b1) begin
            n_bad++; $display("FAIL %s data_valid: got %b expected 1", tag, data_valid);
        end
        n_cmp++;
        if (data !== exp_d) begin
            n_bad++; $display("FAIL %s data: got %h expected %h", tag, data, exp_d);
        end
        n_cmp++;
        if (byte_count !== 4'(kept)) begin
            n_bad++; $display("FAIL %s byte_count: got %0d expected %0d", tag, byte_count, kept);
        end
        n_cmp++;
        if (err_short !== (q.size() < eff)) begin
            n_bad++; $display("FAIL %s err_short: got %b expected %b", tag, err_short, q.size() < eff);
        end
        n_cmp++;
        if (err_overrun !== (q.size() > eff)) begin
            n_bad++; $display("FAIL %s err_overrun: got %b expected %b", tag, err_overrun, q.size() > eff);
        end
        n_cmp++;
        if (group_seq !== 8'(exp_seq)) begin
            n_bad++; $display("FAIL %s group_seq: got %0d expected %0d", tag, group_seq, exp_seq);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++; $display("FAIL %s busy_after_publish: got %b expected 0", tag, busy);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        group_valid = 1'b0; byte_valid = 1'b0; byte_data = '0; group_len = '0; order = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({data, data_valid, byte_count, err_short, err_overrun, group_seq, busy} !== '0) begin
            n_bad++; $display("FAIL reset_outputs: got data=%h dv=%b cnt=%0d es=%b eo=%b seq=%0d busy=%b expected all 0",
                              data, data_valid, byte_count, err_short, err_overrun, group_seq, busy);
        end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || data_valid !== 1'b0) begin
            n_bad++; $display("FAIL reset_idle: got busy=%b dv=%b expected 0 0", busy, data_valid);
        end
    endtask

    task automatic test_directed;
        run_group("T1", 8, 1'b0, 8, 1'b0, 1'b0, 8'h01, 1'b0);
        n_cmp++;
        if (data !== 64'h0102030405060708) begin
            n_bad++; $display("FAIL T1_const: got %h expected 0102030405060708", data);
        end
        run_group("T2", 6, 1'b1, 6, 1'b0, 1'b0, 8'hA0, 1'b1);
        n_cmp++;
        if (data !== 64'h0000A5A4A3A2A1A0) begin
            n_bad++; $display("FAIL T2_const: got %h expected 0000A5A4A3A2A1A0", data);
        end
        run_group("T3", 8, 1'b0, 5, 1'b0, 1'b0, 8'h01, 1'b1);
        n_cmp++;
        if (data !== 64'h0000000102030405) begin
            n_bad++; $display("FAIL T3_const: got %h expected 0000000102030405", data);
        end
        run_group("T4", 4, 1'b0, 6, 1'b0, 1'b0, 8'h10, 1'b1);
        n_cmp++;
        if (data !== 64'h0000000010111213) begin
            n_bad++; $display("FAIL T4_const: got %h expected 0000000010111213", data);
        end
        run_group("T5", 2, 1'b0, 2, 1'b1, 1'b1, 8'h55, 1'b0);
        n_cmp++;
        if (data !== 64'h0000000000005556) begin
            n_bad++; $display("FAIL T5_const: got %h expected 0000000000005556", data);
        end
    endtask

    task automatic test_idle_noise;
        for (int i = 0; i < 8; i++) begin
            group_valid = 1'b0;
            byte_valid  = 1'($urandom);
            byte_data   = 8'($urandom);
            @(negedge clk);
            n_cmp++;
            if (data_valid !== 1'b0 || busy !== 1'b0) begin
                n_bad++; $display("FAIL idle_noise: got dv=%b busy=%b expected 0 0", data_valid, busy);
            end
        end
        byte_valid = 1'b0;
        run_group("after_noise", 3, 1'b1, 3, 1'b0, 1'b0, -1, 1'b1);
    endtask

    task automatic test_random;
        int nb;
        bit br;
        bit bf;
        for (int g = 0; g < 40; g++) begin
            nb = $urandom_range(0, 11);
            br = (nb >= 1) && 1'($urandom);
            bf = (nb - int'(br) >= 1) && 1'($urandom);
            run_group("rand", $urandom_range(0, 15), 1'($urandom), nb, br, bf, -1, 1'b1);
        end
    endtask

    task automatic test_reset_midgroup_and_wrap;
        group_valid = 1'b1; group_len = 4'd8; order = 1'b0;
        for (int i = 0; i < 3; i++) begin
            byte_valid = 1'b1; byte_data = 8'($urandom);
            @(negedge clk);
        end
        rst = 1'b1; group_valid = 1'b0; byte_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({data, data_valid, byte_count, err_short, err_overrun, group_seq, busy} !== '0) begin
            n_bad++; $display("FAIL midreset_outputs: got data=%h dv=%b cnt=%0d es=%b eo=%b seq=%0d busy=%b expected all 0",
                              data, data_valid, byte_count, err_short, err_overrun, group_seq, busy);
        end
        rst = 1'b0;
        exp_seq = 0;
        repeat (2) begin
            @(negedge clk);
            n_cmp++;
            if (data_valid !== 1'b0 || busy !== 1'b0) begin
                n_bad++; $display("FAIL midreset_no_publish: got dv=%b busy=%b expected 0 0", data_valid, busy);
            end
        end
        for (int g = 0; g < 256; g++) begin
            run_group("wrap", 8, 1'($urandom), 8, 1'b0, 1'b0, -1, 1'b0);
        end
        n_cmp++;
        if (group_seq !== 8'd0) begin
            n_bad++; $display("FAIL seq_wrap: got %0d expected 0", group_seq);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_idle_noise();
        test_random();
        test_reset_midgroup_and_wrap();
        @(negedge clk);
        n_cmp++;
        if (data_valid !== 1'b0) begin
            n_bad++; $display("FAIL pulse_width: got %b expected 0", data_valid);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
